// File: rtl/instr_fetch_if.sv
// Instruction-memory and decode handshake bundle for instr_fetch.
// master = fetch unit side, slave = memory/decode environment side.
interface instr_fetch_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_gnt;
  logic                  imem_rvalid;
  logic [31:0]           imem_rdata;

  logic                  instr_valid;
  logic                  instr_ready;
  logic [31:0]           instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;

  logic                  branch;
  logic [ADDR_WIDTH-1:0] branch_target;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output instr_valid, instr, instr_pc, opcode, funct3, funct7,
    input  instr_ready, branch, branch_target
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  instr_valid, instr, instr_pc, opcode, funct3, funct7,
    output instr_ready, branch, branch_target
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word at a time from imem,
// buffers it for decode and applies taken-branch redirects on consume.
module instr_fetch #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  instr_fetch_if.master bus,
  output logic        fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic [31:0]           instr_q, instr_d;
  logic [31:0]           count_q, count_d;
  logic                  fault_q, fault_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      instr_pc_q <= '0;
      instr_q    <= '0;
      count_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_pc_q <= instr_pc_d;
      instr_q    <= instr_d;
      count_q    <= count_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_pc_d = instr_pc_q;
    instr_d    = instr_q;
    count_d    = count_q;
    fault_d    = fault_q;
    unique case (state_q)
      S_REQ: begin
        if (bus.imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          instr_d    = bus.imem_rdata;
          instr_pc_d = pc_q;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.instr_ready) begin
          count_d = count_q + 32'd1;
          if (!bus.branch) begin
            pc_d    = pc_q + PC_STEP;
            state_d = S_REQ;
          end else if (bus.branch_target[1:0] == 2'b00) begin
            pc_d    = bus.branch_target;
            state_d = S_REQ;
          end else begin
            // Misaligned redirect: keep pc, park until reset.
            fault_d = 1'b1;
            state_d = S_FAULT;
          end
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
    endcase
  end

  assign bus.imem_req    = (state_q == S_REQ);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state_q == S_HOLD);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.opcode      = instr_q[6:0];
  assign bus.funct3      = instr_q[14:12];
  assign bus.funct7      = instr_q[31:25];

  assign fault       = fault_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a response scoreboard.
module tb_instr_fetch;

  localparam int unsigned ADDR_WIDTH = 32;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fault;
  logic [31:0] fetch_count;

  instr_fetch_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  instr_fetch #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .RESET_PC  (32'h0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .fault      (fault),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [31:0] exp_pc;
  logic [31:0] exp_count;
  logic        exp_fault;
  logic [31:0] last_word;
  logic [31:0] last_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.imem_gnt      = 1'b0;
    bus.imem_rvalid   = 1'b0;
    bus.imem_rdata    = 32'hDEAD_BEEF;
    bus.instr_ready   = 1'b0;
    bus.branch        = 1'b0;
    bus.branch_target = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    exp_pc    = 32'h0;
    exp_count = 32'h0;
    exp_fault = 1'b0;
    sb.delete();
  endtask

  // Current negedge is in REQ; hold off gnt for gnt_dly cycles, then grant.
  task automatic req_grant(input int gnt_dly);
    chk("req_start", {31'b0, bus.imem_req}, 32'h1);
    chk("addr_start", bus.imem_addr, exp_pc);
    for (int i = 0; i < gnt_dly; i++) begin
      @(negedge clk);
      chk("req_stable", {31'b0, bus.imem_req}, 32'h1);
      chk("addr_stable", bus.imem_addr, exp_pc);
    end
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt = 1'b0;
    chk("req_drop_wait", {31'b0, bus.imem_req}, 32'h0);
  endtask

  // Current negedge is in WAIT; respond after rv_dly idle cycles.
  task automatic respond(input int rv_dly, input logic [31:0] data);
    exp_t e;
    for (int i = 0; i < rv_dly; i++) begin
      chk("valid_low_wait", {31'b0, bus.instr_valid}, 32'h0);
      @(negedge clk);
    end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = data;
    sb.push_back('{word: data, pc: exp_pc});
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = $urandom;
    chk("valid_after_rvalid", {31'b0, bus.instr_valid}, 32'h1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'h0, 32'h1);
    end else begin
      e = sb.pop_front();
      last_word = e.word;
      last_pc   = e.pc;
      chk("instr", bus.instr, e.word);
      chk("instr_pc", bus.instr_pc, e.pc);
      chk("opcode", {25'b0, bus.opcode}, {25'b0, e.word[6:0]});
      chk("funct3", {29'b0, bus.funct3}, {29'b0, e.word[14:12]});
      chk("funct7", {25'b0, bus.funct7}, {25'b0, e.word[31:25]});
    end
  endtask

  // Current negedge is in HOLD; stall for 'stall' cycles, then consume.
  task automatic consume(input int stall, input logic br, input logic [31:0] tgt);
    for (int i = 0; i < stall; i++) begin
      bus.branch        = 1'b1;
      bus.branch_target = 32'h0000_0103;
      bus.imem_gnt      = 1'b1;
      @(negedge clk);
      chk("stall_valid", {31'b0, bus.instr_valid}, 32'h1);
      chk("stall_instr", bus.instr, last_word);
      chk("stall_pc", bus.instr_pc, last_pc);
      chk("stall_noreq", {31'b0, bus.imem_req}, 32'h0);
      chk("stall_count", fetch_count, exp_count);
    end
    bus.imem_gnt      = 1'b0;
    bus.instr_ready   = 1'b1;
    bus.branch        = br;
    bus.branch_target = tgt;
    exp_count = exp_count + 32'd1;
    if (!br) exp_pc = exp_pc + 32'd4;
    else if (tgt[1:0] == 2'b00) exp_pc = tgt;
    else exp_fault = 1'b1;
    @(negedge clk);
    bus.instr_ready   = 1'b0;
    bus.branch        = 1'b0;
    bus.branch_target = '0;
    chk("count", fetch_count, exp_count);
    chk("fault", {31'b0, fault}, {31'b0, exp_fault});
    chk("valid_after_consume", {31'b0, bus.instr_valid}, 32'h0);
    if (exp_fault) chk("fault_noreq", {31'b0, bus.imem_req}, 32'h0);
  endtask

  initial begin
    drive_idle();
    // Reset state and first request at RESET_PC
    do_reset();
    chk("rst_req", {31'b0, bus.imem_req}, 32'h1);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);

    // Zero-wait fetch of addi x1,x0,5
    req_grant(0);
    respond(0, 32'h0050_0093);
    chk("addi_opcode", {25'b0, bus.opcode}, 32'h13);
    consume(0, 1'b0, 32'h0);

    // Delayed grant and response, then decode stall
    req_grant(3);
    respond(2, 32'h00A0_0113);
    consume(5, 1'b0, 32'h0);

    // Aligned branch from 0x8 to 0x40, then sequential to 0x44
    req_grant(0);
    respond(0, 32'h0020_8463);
    chk("branch_src_pc", bus.instr_pc, 32'h8);
    consume(0, 1'b1, 32'h40);
    req_grant(1);
    respond(0, 32'h4020_5233);
    consume(0, 1'b0, 32'h0);
    chk("seq_after_branch", bus.imem_addr, 32'h44);

    // PC wrap from the top of the address space
    req_grant(0);
    respond(1, 32'hFE00_0EE3);
    consume(1, 1'b1, 32'hFFFF_FFFC);
    req_grant(0);
    respond(0, 32'h0000_0013);
    consume(0, 1'b0, 32'h0);
    chk("pc_wrap", bus.imem_addr, 32'h0);

    // Misaligned redirect -> sticky fault, memory activity ignored
    req_grant(0);
    respond(0, 32'h0000_0063);
    consume(0, 1'b1, 32'h42);
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fault_hold_req", {31'b0, bus.imem_req}, 32'h0);
      chk("fault_hold_valid", {31'b0, bus.instr_valid}, 32'h0);
      chk("fault_hold_flag", {31'b0, fault}, 32'h1);
      chk("fault_hold_count", fetch_count, exp_count);
    end
    do_reset();
    chk("post_fault_flag", {31'b0, fault}, 32'h0);
    chk("post_fault_addr", bus.imem_addr, 32'h0);
    chk("post_fault_count", fetch_count, 32'h0);

    // Reset while in WAIT, stale response after release must be ignored
    req_grant(0);
    respond(0, 32'h0000_0093);
    consume(0, 1'b0, 32'h0);
    req_grant(1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    exp_pc    = 32'h0;
    exp_count = 32'h0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBAD0_0BAD;
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    chk("stale_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("stale_instr", bus.instr, 32'h0);
    chk("stale_count", fetch_count, 32'h0);
    req_grant(0);
    respond(0, 32'h1234_5678);
    consume(0, 1'b0, 32'h0);
    chk("sb_empty", sb.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
